// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the sequencer state enum, register-address width and the x0 address.
package core_pkg;

    // Width of the rs1/rs2/rd register-address fields.
    localparam int REG_AW = 5;

    // Address of the hard-wired zero register.
    localparam logic [REG_AW-1:0] X0_ADDR = '0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID and EX stages.
// Ports: i ID sources/use flags/valid, EX load/rd/valid; o lu (stall request).
module hazard_detect
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_valid,
    output logic              lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_ex_load;

    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

    // A load writing x0 produces nothing a consumer could wait for.
    assign w_ex_load = ex_valid && ex_is_load && (ex_rd != X0_ADDR);

    assign lu = w_ex_load && id_valid && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: PC/IF-ID/ID-EX/EX-MEM enables, flushes, halt and boot.
// Ports: clk, rst, memory ready flags, ID/EX hazard info, branch_taken,
//        halt_req, resume; outputs are stage controls, halted and counters.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int START_DELAY = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_valid,
    input  logic              branch_taken,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_we,
    output logic              fetch_valid,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_flush,
    output logic              ex_mem_we,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [3:0] BOOT_LAST = 4'(START_DELAY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_boot_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;
    logic             w_stall_inc;
    logic             w_flush_inc;

    hazard_detect u_hazard (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_valid   (id_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_valid   (ex_valid),
        .lu         (w_lu)
    );

    always_comb begin
        w_next      = r_state;
        pc_we       = 1'b0;
        fetch_valid = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_we    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b0;
        halted      = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;

        unique case (r_state)
            BOOT: begin
                // Keep the pipe full of bubbles until fetch starts.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (r_boot_cnt == BOOT_LAST) begin
                    w_next = RUN;
                end
            end

            RUN: begin
                if (!dmem_ready) begin
                    // Whole pipe frozen; branch/load-use wait for MEM.
                    w_stall_inc = 1'b1;
                end else if (branch_taken) begin
                    // ID instruction dies, so its hazards are moot.
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_we    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_lu) begin
                    // Hold IF/ID and PC, inject one bubble into EX.
                    id_ex_we    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_we   = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (!imem_ready) begin
                    // IF/ID captures a not-running slot.
                    if_id_we    = 1'b1;
                    id_ex_we    = 1'b1;
                    ex_mem_we   = 1'b1;
                    w_stall_inc = 1'b1;
                end else begin
                    pc_we       = 1'b1;
                    fetch_valid = 1'b1;
                    if_id_we    = 1'b1;
                    id_ex_we    = 1'b1;
                    ex_mem_we   = 1'b1;
                end

                // A coincident resume cancels the halt.
                if (halt_req && !resume) begin
                    w_next = HALT;
                end
            end

            HALT: begin
                halted = 1'b1;
                if (resume) begin
                    w_next = RUN;
                end
            end

            default: begin
                w_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BOOT;
            r_boot_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == BOOT) begin
                r_boot_cnt <= r_boot_cnt + 4'd1;
            end
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed plan then random traffic.
// A cycle-level behavioural model predicts controls and counters.
module tb_pipe_ctrl;

    localparam int SD = 2;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_ready, dmem_ready;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, id_valid;
    logic          ex_is_load, ex_valid;
    logic          branch_taken, halt_req, resume;
    logic          pc_we, fetch_valid, if_id_we, if_id_flush;
    logic          id_ex_we, id_ex_flush, ex_mem_we, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: mode 0=booting, 1=running, 2=halted.
    int      m_mode;
    int      m_boot;
    int      m_stall;
    int      m_flush;
    bit      m_known = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl #(.START_DELAY(SD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_valid(id_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_valid(ex_valid),
        .branch_taken(branch_taken), .halt_req(halt_req),
        .resume(resume),
        .pc_we(pc_we), .fetch_valid(fetch_valid),
        .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
        .ex_mem_we(ex_mem_we), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu();
        bit h1, h2;
        h1 = id_use_rs1 && (id_rs1 == ex_rd);
        h2 = id_use_rs2 && (id_rs2 == ex_rd);
        return ex_valid && ex_is_load && id_valid && (ex_rd != 0) && (h1 || h2);
    endfunction

    // Bits: pc_we fetch_valid if_id_we if_id_flush id_ex_we id_ex_flush
    //       ex_mem_we halted. Mask clears bits the rules leave open.
    task automatic cyc();
        logic [7:0] e, k, o;
        #1;
        k = 8'hff;
        if (m_mode == 0) e = 8'b0001_0100;
        else if (m_mode == 2) e = 8'b0000_0001;
        else if (!dmem_ready) e = 8'b0000_0000;
        else if (branch_taken) begin
            e = 8'b1001_0110; k = 8'b1101_0111;
        end else if (model_lu()) begin
            e = 8'b0000_0110; k = 8'b1010_0111;
        end else if (!imem_ready) e = 8'b0010_1010;
        else e = 8'b1110_1010;
        o = {pc_we, fetch_valid, if_id_we, if_id_flush,
             id_ex_we, id_ex_flush, ex_mem_we, halted};
        if (m_known) begin
            chk("ctrl", {24'd0, o & k}, {24'd0, e & k});
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_mode = 0; m_boot = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode == 0) begin
            if (m_boot == SD - 1) m_mode = 1;
            m_boot++;
        end else if (m_mode == 1) begin
            if (!dmem_ready) m_stall++;
            else if (branch_taken) m_flush++;
            else if (model_lu() || !imem_ready) m_stall++;
            if (halt_req && !resume) m_mode = 2;
        end else if (resume) begin
            m_mode = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; imem_ready = 1; dmem_ready = 1;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_valid = 0;
        ex_is_load = 0; ex_valid = 0;
        branch_taken = 0; halt_req = 0; resume = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_use_rs2 = 1; id_rs2 = rd;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        // Reset and boot delay.
        repeat (3) cyc();
        rst = 0;
        repeat (SD) cyc();
        cyc();
        chk("run_after_boot", {31'd0, pc_we}, 32'd1);
        // Load-use gives one bubble; x0 never stalls.
        set_lu(5'd5); cyc();
        idle(); cyc();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        set_lu(5'd0); cyc();
        idle(); cyc();
        // Branch beats load-use.
        set_lu(5'd7); branch_taken = 1; cyc();
        idle(); cyc();
        // Freeze defers the branch.
        branch_taken = 1; dmem_ready = 0;
        repeat (3) cyc();
        dmem_ready = 1; cyc();
        idle(); cyc();
        chk("freeze_stall_cnt", stall_cnt, 32'd4);
        chk("freeze_flush_cnt", flush_cnt, 32'd2);
        // Fetch wait.
        imem_ready = 0; repeat (2) cyc();
        idle(); cyc();
        // Halt for 4 cycles, then resume.
        halt_req = 1; cyc();
        halt_req = 0; repeat (3) cyc();
        resume = 1; cyc();
        resume = 0; cyc();
        chk("resumed", {31'd0, halted}, 32'd0);
        // Halt and resume together stay in run.
        halt_req = 1; resume = 1; cyc();
        idle(); cyc();
        // Reset in the middle of a halt.
        halt_req = 1; cyc();
        idle(); repeat (2) cyc();
        rst = 1; cyc();
        rst = 0; cyc();
        chk("rst_clears_stall", stall_cnt, 32'd0);
        chk("rst_clears_flush", flush_cnt, 32'd0);
        repeat (SD + 1) cyc();
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(99) == 0);
            imem_ready   = ($urandom_range(4) != 0);
            dmem_ready   = ($urandom_range(5) != 0);
            id_rs1       = 5'($urandom_range(3));
            id_rs2       = 5'($urandom_range(3));
            ex_rd        = 5'($urandom_range(3));
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            id_valid     = 1'($urandom);
            ex_is_load   = 1'($urandom);
            ex_valid     = 1'($urandom);
            branch_taken = ($urandom_range(5) == 0);
            halt_req     = ($urandom_range(19) == 0);
            resume       = ($urandom_range(3) == 0);
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
